// File: rtl/acc_aom_trigger_gen_pkg.sv
// Shared definitions for the ACC AOM trigger generator: FSM state encoding
// and default configuration constants, also used by the ACC register map.
package acc_aom_trigger_gen_pkg;

    // Trigger conditioning FSM states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DELAY   = 2'd1,
        ST_ACTIVE  = 2'd2,
        ST_HOLDOFF = 2'd3
    } acc_state_e;

    // Structural defaults
    localparam int ACC_SYNC_STAGES_DEF = 2;
    localparam int ACC_FILT_W_DEF      = 8;
    localparam int ACC_CNT_W_DEF       = 16;

    // Register-map reset values for the run-time configuration
    localparam int ACC_FILTER_LEN_DEF  = 3;
    localparam int ACC_DELAY_DEF       = 10;
    localparam int ACC_WIDTH_DEF       = 5;
    localparam int ACC_HOLDOFF_DEF     = 0;

endpackage

// File: rtl/acc_glitch_filter.sv
// Input conditioning for the raw trigger: synchronizer chain, symmetric
// run-length glitch filter and a registered strobe on each filtered rise.
module acc_glitch_filter
    import acc_aom_trigger_gen_pkg::*;
#(
    parameter int SYNC_STAGES = ACC_SYNC_STAGES_DEF,
    parameter int FILT_W      = ACC_FILT_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              trig_i,
    input  logic [FILT_W-1:0] filter_len_i,
    output logic              rise_o
);

    localparam logic [FILT_W-1:0] RUN_ONE = {{(FILT_W-1){1'b0}}, 1'b1};

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   level_q, level_d;
    logic [FILT_W-1:0]      run_q, run_d;
    logic                   rise_q, rise_d;
    logic                   sync_w;

    assign sync_w = sync_q[SYNC_STAGES-1];

    // Next-state: shift the sync chain, count consecutive samples that
    // disagree with the filtered level, and flip the level once the run
    // reaches L+1 samples. Any agreeing sample restarts the run. The >=
    // compare keeps the run from wrapping if L is lowered mid-run.
    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], trig_i};
        level_d = level_q;
        run_d   = '0;
        rise_d  = 1'b0;
        if (sync_w != level_q) begin
            if (run_q >= filter_len_i) begin
                level_d = sync_w;
                rise_d  = sync_w;
            end else begin
                run_d = run_q + RUN_ONE;
            end
        end
    end

    // Filter state registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            run_q   <= '0;
            rise_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            level_q <= level_d;
            run_q   <= run_d;
            rise_q  <= rise_d;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/acc_aom_trigger_gen.sv
// ACC AOM trigger generator: conditions the raw accelerometer/stage trigger
// into a delayed, fixed-width AOM control flag with hold-off, and counts
// triggers that arrive while a previous one is still being served.
module acc_aom_trigger_gen
    import acc_aom_trigger_gen_pkg::*;
#(
    parameter int SYNC_STAGES = ACC_SYNC_STAGES_DEF,
    parameter int FILT_W      = ACC_FILT_W_DEF,
    parameter int CNT_W       = ACC_CNT_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              laser_start_i,
    input  logic              acc_trigger_i,
    input  logic              cfg_enable_i,
    input  logic [FILT_W-1:0] cfg_filter_len_i,
    input  logic [CNT_W-1:0]  cfg_delay_i,
    input  logic [CNT_W-1:0]  cfg_width_i,
    input  logic [CNT_W-1:0]  cfg_holdoff_i,
    output logic              aom_ctrl_flag_o,
    output logic              busy_o,
    output logic [CNT_W-1:0]  missed_trigger_num_o
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    acc_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] width_q, width_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic             flag_q, flag_d;
    logic [CNT_W-1:0] miss_q, miss_d;
    logic             ls_q;

    logic             event_w;
    logic             ls_rise_w;
    logic [CNT_W-1:0] width_eff_w;

    acc_glitch_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_W      (FILT_W)
    ) u_filter (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .trig_i       (acc_trigger_i),
        .filter_len_i (cfg_filter_len_i),
        .rise_o       (event_w)
    );

    // A zero width still produces a one-cycle flag
    assign width_eff_w = (cfg_width_i == '0) ? CNT_ONE : cfg_width_i;
    assign ls_rise_w   = laser_start_i & ~ls_q;

    // FSM next state: one shared down-counter serves delay, width and
    // hold-off. Width and hold-off are latched on leaving IDLE so config
    // changes mid-pulse only affect the next event. Disable aborts.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        width_d = width_q;
        hold_d  = hold_q;
        if (!cfg_enable_i) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (event_w) begin
                        width_d = width_eff_w;
                        hold_d  = cfg_holdoff_i;
                        if (cfg_delay_i != '0) begin
                            state_d = ST_DELAY;
                            cnt_d   = cfg_delay_i - CNT_ONE;
                        end else begin
                            state_d = ST_ACTIVE;
                            cnt_d   = width_eff_w - CNT_ONE;
                        end
                    end
                end
                ST_DELAY: begin
                    if (cnt_q == '0) begin
                        state_d = ST_ACTIVE;
                        cnt_d   = width_q - CNT_ONE;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                ST_ACTIVE: begin
                    if (cnt_q == '0) begin
                        if (hold_q != '0) begin
                            state_d = ST_HOLDOFF;
                            cnt_d   = hold_q - CNT_ONE;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                ST_HOLDOFF: begin
                    if (cnt_q == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        flag_d = (state_d == ST_ACTIVE);
    end

    // Miss counter: a laser_start rise clears it and wins over a
    // coincident miss; otherwise count busy-time events, saturating.
    always_comb begin
        miss_d = miss_q;
        if (ls_rise_w) begin
            miss_d = '0;
        end else if (event_w && cfg_enable_i && (state_q != ST_IDLE)
                     && (miss_q != '1)) begin
            miss_d = miss_q + CNT_ONE;
        end
    end

    // State, counters, flag and miss count registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            width_q <= CNT_ONE;
            hold_q  <= '0;
            flag_q  <= 1'b0;
            miss_q  <= '0;
            ls_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            width_q <= width_d;
            hold_q  <= hold_d;
            flag_q  <= flag_d;
            miss_q  <= miss_d;
            ls_q    <= laser_start_i;
        end
    end

    assign aom_ctrl_flag_o      = flag_q;
    assign busy_o               = (state_q != ST_IDLE);
    assign missed_trigger_num_o = miss_q;

endmodule

// File: tb/tb_acc_aom_trigger_gen.sv
// Self-checking bench for acc_aom_trigger_gen. A timeline reference model
// (input history window for the filter, scheduled flag/busy intervals for
// the pulse generator) is compared against the DUT after every clock edge.
module tb_acc_aom_trigger_gen;

    localparam int S    = 2;
    localparam int FW   = 8;
    localparam int CW   = 16;
    localparam int MAXC = 16384;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic          laser_start_i = 1'b0;
    logic          acc_trigger_i = 1'b0;
    logic          cfg_enable_i = 1'b1;
    logic [FW-1:0] cfg_filter_len = '0;
    logic [CW-1:0] cfg_delay = '0;
    logic [CW-1:0] cfg_width = '0;
    logic [CW-1:0] cfg_holdoff = '0;
    logic          flag, busy;
    logic [CW-1:0] miss;
    logic          flag4, busy4;
    logic [3:0]    miss4;

    always #5 clk = ~clk;

    acc_aom_trigger_gen #(.SYNC_STAGES(S), .FILT_W(FW), .CNT_W(CW)) u_dut (
        .clk_i(clk), .rst_i(rst_i), .laser_start_i(laser_start_i),
        .acc_trigger_i(acc_trigger_i), .cfg_enable_i(cfg_enable_i),
        .cfg_filter_len_i(cfg_filter_len), .cfg_delay_i(cfg_delay),
        .cfg_width_i(cfg_width), .cfg_holdoff_i(cfg_holdoff),
        .aom_ctrl_flag_o(flag), .busy_o(busy), .missed_trigger_num_o(miss)
    );

    // Narrow-counter instance so miss-count saturation is reachable quickly
    acc_aom_trigger_gen #(.SYNC_STAGES(S), .FILT_W(FW), .CNT_W(4)) u_dut_sat (
        .clk_i(clk), .rst_i(rst_i), .laser_start_i(laser_start_i),
        .acc_trigger_i(acc_trigger_i), .cfg_enable_i(cfg_enable_i),
        .cfg_filter_len_i(cfg_filter_len), .cfg_delay_i(cfg_delay[3:0]),
        .cfg_width_i(cfg_width[3:0]), .cfg_holdoff_i(cfg_holdoff[3:0]),
        .aom_ctrl_flag_o(flag4), .busy_o(busy4), .missed_trigger_num_o(miss4)
    );

    int checks = 0;
    int errors = 0;
    int n = 0;

    // reference model state
    bit hist [MAXC];
    int m_base = 0;
    bit m_level = 0, m_strobe = 0, m_ls_prev = 0;
    int m_idle_at = 0, m_fs = 0, m_fe = 0;
    int m_miss = 0, m_raw = 0;
    bit sat_on = 0;

    // observation bookkeeping
    bit flag_prev = 0;
    int rises = 0, hi_cnt = 0, rise_cyc = -1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h cycle=%0d", tag, got, exp, n);
        end
    endtask

    function automatic bit samp(input int idx);
        if (idx < m_base || idx < 0) return 1'b0;
        return hist[idx];
    endfunction

    // Advance the model by one clock edge using the inputs sampled there
    task automatic model_step();
        bit ev, all_diff, busy_prev, ls_rise;
        int wp;
        if (n < MAXC) hist[n] = acc_trigger_i;
        if (rst_i) begin
            m_base = n + 1; m_level = 0; m_strobe = 0; m_ls_prev = 0;
            m_idle_at = n; m_fs = 0; m_fe = 0; m_miss = 0; m_raw = 0;
            return;
        end
        ev = m_strobe;
        // filter: flip once the last L+1 synchronized samples all disagree
        all_diff = 1;
        for (int k = 0; k <= int'(cfg_filter_len); k++)
            if (samp(n - S - k) == m_level) all_diff = 0;
        m_strobe = 0;
        if (all_diff) begin
            m_level  = !m_level;
            m_strobe = m_level;
        end
        busy_prev = (n - 1 < m_idle_at);
        ls_rise   = laser_start_i && !m_ls_prev;
        m_ls_prev = laser_start_i;
        if (!cfg_enable_i) begin
            m_idle_at = n;
            m_fe = n;
        end else if (ev) begin
            if (!busy_prev) begin
                wp = (cfg_width == 0) ? 1 : int'(cfg_width);
                m_fs = n + int'(cfg_delay);
                m_fe = m_fs + wp;
                m_idle_at = m_fe + int'(cfg_holdoff);
            end else begin
                m_raw++;
                if (m_miss < 65535) m_miss++;
            end
        end
        if (ls_rise) begin
            m_miss = 0;
            m_raw = 0;
        end
    endtask

    task automatic tick();
        bit ef;
        @(posedge clk);
        n++;
        model_step();
        #1;
        ef = (m_fs <= n) && (n < m_fe);
        chk("flag", flag, ef);
        chk("busy", busy, n < m_idle_at);
        chk("miss", miss, m_miss);
        if (sat_on) begin
            chk("sat_flag", flag4, ef);
            chk("sat_busy", busy4, n < m_idle_at);
            chk("sat_miss", miss4, (m_raw > 15) ? 15 : m_raw);
        end
        if (flag && !flag_prev) begin
            rises++;
            rise_cyc = n;
        end
        if (flag) hi_cnt++;
        flag_prev = flag;
    endtask

    task automatic idle(input int c);
        repeat (c) tick();
    endtask

    task automatic setcfg(input int l, input int d, input int w, input int h);
        cfg_filter_len = FW'(l);
        cfg_delay      = CW'(d);
        cfg_width      = CW'(w);
        cfg_holdoff    = CW'(h);
    endtask

    task automatic do_reset();
        rst_i = 1; acc_trigger_i = 0; laser_start_i = 0;
        tick(); tick();
        chk("rst_flag", flag, 0);
        chk("rst_busy", busy, 0);
        chk("rst_miss", miss, 0);
        rst_i = 0;
    endtask

    initial begin
        int e, saved, found, run_left;

        do_reset();
        idle(5);

        // 1: clean rise, L=3 D=10 W=5 H=0
        setcfg(3, 10, 5, 0);
        rises = 0; hi_cnt = 0;
        acc_trigger_i = 1;
        tick();
        e = n;
        idle(30);
        chk("t1_rise_cycle", rise_cyc, e + 16);
        chk("t1_width", hi_cnt, 5);
        chk("t1_rises", rises, 1);
        chk("t1_busy_end", busy, 0);
        acc_trigger_i = 0;
        idle(10);
        $display("scenario 1 clean pulse done, cycle %0d", n);

        // 2: 3-cycle glitch rejected, 4-cycle pulse accepted
        setcfg(3, 2, 3, 0);
        rises = 0;
        acc_trigger_i = 1; idle(3);
        acc_trigger_i = 0; idle(10);
        acc_trigger_i = 1; idle(4);
        acc_trigger_i = 0; idle(30);
        chk("t2_rises", rises, 1);
        chk("t2_miss", miss, 0);
        $display("scenario 2 glitch filter done, cycle %0d", n);

        // 3: events 10 apart inside a 21-cycle busy window
        setcfg(0, 0, 0, 20);
        rises = 0; hi_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            acc_trigger_i = 1; idle(3);
            acc_trigger_i = 0; idle(7);
        end
        idle(20);
        chk("t3_rises", rises, 1);
        chk("t3_width", hi_cnt, 1);
        chk("t3_miss", miss, 2);
        laser_start_i = 1;
        tick();
        chk("t3_clear", miss, 0);
        laser_start_i = 0;
        idle(5);
        $display("scenario 3 miss count done, cycle %0d", n);

        // 4: saturation on a 4-bit counter, then clear beats coincident miss
        do_reset();
        sat_on = 1;
        setcfg(0, 0, 0, 15);
        for (int i = 0; i < 120; i++) begin
            acc_trigger_i = ~acc_trigger_i;
            tick();
        end
        chk("t4_sat", miss4, 4'hF);
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            acc_trigger_i = ~acc_trigger_i;
            if (m_strobe && (n < m_idle_at)) begin
                laser_start_i = 1;
                tick();
                chk("t4_coinc_main", miss, 0);
                chk("t4_coinc_sat", miss4, 0);
                laser_start_i = 0;
                found = 1;
            end else begin
                tick();
            end
        end
        chk("t4_coinc_found", found, 1);
        acc_trigger_i = 0;
        idle(20);
        sat_on = 0;
        $display("scenario 4 saturation done, cycle %0d", n);

        // 5: disable mid-ACTIVE, re-enable with input held high
        setcfg(2, 0, 10, 0);
        acc_trigger_i = 1;
        for (int i = 0; i < 30 && !flag; i++) tick();
        chk("t5_flag_seen", flag, 1);
        idle(3);
        saved = int'(miss);
        cfg_enable_i = 0;
        tick();
        chk("t5_abort_flag", flag, 0);
        chk("t5_abort_busy", busy, 0);
        chk("t5_abort_miss", miss, saved);
        idle(5);
        cfg_enable_i = 1;
        rises = 0;
        idle(30);
        chk("t5_no_false_edge", rises, 0);
        acc_trigger_i = 0; idle(10);
        acc_trigger_i = 1; idle(30);
        chk("t5_new_rise", rises, 1);
        acc_trigger_i = 0; idle(10);
        $display("scenario 5 enable abort done, cycle %0d", n);

        // 6: reset mid-DELAY and mid-ACTIVE
        setcfg(1, 20, 5, 0);
        acc_trigger_i = 1;
        for (int i = 0; i < 20 && !busy; i++) tick();
        idle(3);
        chk("t6_in_delay", {busy, flag}, 2'b10);
        rst_i = 1; acc_trigger_i = 0;
        tick();
        chk("t6_delay_flag", flag, 0);
        chk("t6_delay_busy", busy, 0);
        chk("t6_delay_miss", miss, 0);
        rst_i = 0;
        idle(10);
        setcfg(1, 0, 8, 0);
        acc_trigger_i = 1;
        for (int i = 0; i < 20 && !flag; i++) tick();
        tick();
        chk("t6_in_active", flag, 1);
        rst_i = 1; acc_trigger_i = 0;
        tick();
        chk("t6_active_flag", flag, 0);
        chk("t6_active_busy", busy, 0);
        rst_i = 0;
        idle(10);
        $display("scenario 6 mid-pulse reset done, cycle %0d", n);

        // random run against the model
        rises = 0;
        run_left = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0) cfg_filter_len = FW'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) begin
                cfg_delay   = CW'($urandom_range(0, 12));
                cfg_width   = CW'($urandom_range(0, 8));
                cfg_holdoff = CW'($urandom_range(0, 12));
            end
            if (run_left == 0) begin
                acc_trigger_i = ~acc_trigger_i;
                run_left = $urandom_range(1, 10);
            end
            run_left--;
            cfg_enable_i  = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 39) == 0) laser_start_i = ~laser_start_i;
            rst_i = ($urandom_range(0, 999) == 0);
            tick();
        end
        rst_i = 0; cfg_enable_i = 1;
        chk("rnd_activity", rises > 10, 1);
        $display("scenario random done, cycle %0d", n);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
